// File: rtl/marker_pattern_gen.sv
// Raster test-pattern source: banded marker inside a configurable rectangle on a white field,
// plus registered raster counters, row/frame strobes and the expected centre hcount.
module marker_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int SIDE_BANDS = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic [9:0]  height_in,
    input  logic [7:0]  width_in,
    output logic [2:0]  rgb_out,
    output logic        active_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        row_start_out,
    output logic        frame_start_out,
    output logic [10:0] centre_out
);

    localparam logic [1:0] ST_QUIET = 2'd0;
    localparam logic [1:0] ST_BAND  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [3:0] LAST_BAND   = 4'(2 * SIDE_BANDS);
    localparam logic [3:0] CENTRE_BAND = 4'(SIDE_BANDS);

    // Internal raster runs one cycle ahead of the registered outputs.
    logic [10:0] hCnt_q, hCnt_d;
    logic [9:0]  vCnt_q, vCnt_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  band_q, band_d;
    logic [8:0]  pix_q, pix_d;

    logic [10:0] xLat_q;
    logic [9:0]  yLat_q;
    logic [9:0]  heightLat_q;
    logic [7:0]  widthLat_q;

    logic [2:0]  rgb_q, rgb_d;
    logic        active_q, active_d;
    logic [10:0] hOut_q;
    logic [9:0]  vOut_q;
    logic        rowStart_q;
    logic        frameStart_q;
    logic [10:0] centre_q;

    logic        atOrigin;
    logic [10:0] xCfg;
    logic [9:0]  yCfg;
    logic [9:0]  heightCfg;
    logic [7:0]  widthCfg;
    logic [8:0]  widthEff;
    logic [10:0] rowEnd;
    logic        markerRow;
    logic        hActive;
    logic        vActive;
    logic [10:0] centreCalc;

    logic [1:0]  curState;
    logic [1:0]  pixState;
    logic [3:0]  pixBand;
    logic [8:0]  pixPix;
    logic [8:0]  bandLen;

    // At the frame origin the live inputs are used so pixel (0,0) already sees the new frame's config.
    assign atOrigin  = (hCnt_q == 11'd0) && (vCnt_q == 10'd0);
    assign xCfg      = atOrigin ? x_in      : xLat_q;
    assign yCfg      = atOrigin ? y_in      : yLat_q;
    assign heightCfg = atOrigin ? height_in : heightLat_q;
    assign widthCfg  = atOrigin ? width_in  : widthLat_q;
    assign widthEff  = (widthCfg == 8'd0) ? 9'd1 : {1'b0, widthCfg};

    assign rowEnd     = {1'b0, yCfg} + {1'b0, heightCfg};
    assign markerRow  = ({1'b0, vCnt_q} >= {1'b0, yCfg}) && ({1'b0, vCnt_q} < rowEnd);
    assign hActive    = hCnt_q < 11'(H_ACTIVE);
    assign vActive    = vCnt_q < 10'(V_ACTIVE);
    assign centreCalc = xCfg + 11'(SIDE_BANDS + 1) * {2'b00, widthEff};

    always_comb begin
        hCnt_d = hCnt_q + 11'd1;
        vCnt_d = vCnt_q;
        if (hCnt_q == 11'(H_TOTAL - 1)) begin
            hCnt_d = 11'd0;
            if (vCnt_q == 10'(V_TOTAL - 1)) begin
                vCnt_d = 10'd0;
            end else begin
                vCnt_d = vCnt_q + 10'd1;
            end
        end
    end

    // Resolve the band state that applies to the current pixel; every row restarts in QUIET.
    always_comb begin
        curState = (hCnt_q == 11'd0) ? ST_QUIET : state_q;
        pixState = curState;
        pixBand  = band_q;
        pixPix   = pix_q;
        if (!hActive) begin
            pixState = ST_DONE;
        end else if (curState == ST_QUIET && markerRow && hCnt_q == xCfg) begin
            pixState = ST_BAND;
            pixBand  = 4'd0;
            pixPix   = 9'd0;
        end
        bandLen = (pixBand == CENTRE_BAND) ? (widthEff << 1) : widthEff;
    end

    always_comb begin
        state_d = pixState;
        band_d  = pixBand;
        pix_d   = pixPix;
        if (pixState == ST_BAND) begin
            if (pixPix == bandLen - 9'd1) begin
                pix_d = 9'd0;
                if (pixBand == LAST_BAND) begin
                    state_d = ST_DONE;
                end else begin
                    band_d = pixBand + 4'd1;
                end
            end else begin
                pix_d = pixPix + 9'd1;
            end
        end
    end

    // Even bands are black, odd bands white; the centre band keeps its parity colour.
    always_comb begin
        rgb_d    = 3'b111;
        active_d = hActive && vActive;
        if (!active_d) begin
            rgb_d = 3'b000;
        end else if (pixState == ST_BAND) begin
            rgb_d = pixBand[0] ? 3'b111 : 3'b000;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hCnt_q       <= 11'd0;
            vCnt_q       <= 10'd0;
            state_q      <= ST_QUIET;
            band_q       <= 4'd0;
            pix_q        <= 9'd0;
            xLat_q       <= 11'd0;
            yLat_q       <= 10'd0;
            heightLat_q  <= 10'd0;
            widthLat_q   <= 8'd0;
            rgb_q        <= 3'b000;
            active_q     <= 1'b0;
            hOut_q       <= 11'd0;
            vOut_q       <= 10'd0;
            rowStart_q   <= 1'b0;
            frameStart_q <= 1'b0;
            centre_q     <= 11'd0;
        end else if (enable_in) begin
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            state_q      <= state_d;
            band_q       <= band_d;
            pix_q        <= pix_d;
            rgb_q        <= rgb_d;
            active_q     <= active_d;
            hOut_q       <= hCnt_q;
            vOut_q       <= vCnt_q;
            rowStart_q   <= (hCnt_q == 11'd0);
            frameStart_q <= atOrigin;
            if (atOrigin) begin
                xLat_q      <= x_in;
                yLat_q      <= y_in;
                heightLat_q <= height_in;
                widthLat_q  <= width_in;
                centre_q    <= centreCalc;
            end
        end
    end

    assign rgb_out         = rgb_q;
    assign active_out      = active_q;
    assign hcount_out      = hOut_q;
    assign vcount_out      = vOut_q;
    assign row_start_out   = rowStart_q;
    assign frame_start_out = frameStart_q;
    assign centre_out      = centre_q;

endmodule

// File: tb/tb_marker_pattern_gen.sv
// Directed bench for marker_pattern_gen: short frames (16 rows) keep full-frame timing checks cheap
// while the 640/800 horizontal geometry keeps the clipping cases meaningful.
module tb_marker_pattern_gen;

    localparam int HA = 640;
    localparam int HT = 800;
    localparam int VA = 15;
    localparam int VT = 16;
    localparam int SB = 3;

    localparam logic [2:0] B = 3'b000;
    localparam logic [2:0] W = 3'b111;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [9:0]  height_in;
    logic [7:0]  width_in;
    logic [2:0]  rgb_out;
    logic        active_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        row_start_out;
    logic        frame_start_out;
    logic [10:0] centre_out;

    int errors = 0;
    int checks = 0;

    logic [2:0] rowRgb [0:HT-1];
    logic       rowAct [0:HT-1];

    int   enCycles;
    logic monitorOn = 1'b0;
    logic rowSeen = 1'b0;
    int   lastRow = 0;
    int   rowPulses = 0;
    int   badRowGaps = 0;
    int   frameCnt = 0;
    int   frameStamp [0:7];
    int   frameRows [0:7];

    marker_pattern_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .SIDE_BANDS(SB)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .x_in(x_in), .y_in(y_in), .height_in(height_in), .width_in(width_in),
        .rgb_out(rgb_out), .active_out(active_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .row_start_out(row_start_out), .frame_start_out(frame_start_out),
        .centre_out(centre_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) enCycles <= 0;
        else if (enable_in) enCycles <= enCycles + 1;
    end

    // Strobe monitor: row spacing in enabled cycles, frame start stamps and rows per frame.
    always @(negedge clk_in) begin
        if (monitorOn && !rst_in) begin
            if (row_start_out) begin
                if (rowSeen && (enCycles - lastRow) != HT) badRowGaps <= badRowGaps + 1;
                lastRow   <= enCycles;
                rowSeen   <= 1'b1;
                rowPulses <= rowPulses + 1;
            end
            if (frame_start_out && frameCnt < 8) begin
                frameStamp[frameCnt] <= enCycles;
                frameRows[frameCnt]  <= rowPulses;
                frameCnt             <= frameCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
        checks++;
        if (obs !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expVal);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input int h, input int w);
        x_in      = 11'(x);
        y_in      = 10'(y);
        height_in = 10'(h);
        width_in  = 8'(w);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic advanceTo(input int v, input int h);
        int n = 0;
        while (!(hcount_out == 11'(h) && vcount_out == 10'(v)) && n < 20000) begin
            tick();
            n++;
        end
        checkOutput($sformatf("reach v%0d h%0d", v, h), {31'd0, n < 20000}, 32'd1);
    endtask

    task automatic captureRow(input int v);
        advanceTo(v, 0);
        for (int i = 0; i < HT; i++) begin
            rowRgb[i] = rgb_out;
            rowAct[i] = active_out;
            if (i < HT - 1) tick();
        end
    endtask

    task automatic spot(input string tag, input int h, input logic [2:0] expRgb);
        checkOutput($sformatf("%s h%0d", tag, h), {29'd0, rowRgb[h]}, {29'd0, expRgb});
    endtask

    // Plain active row: white with active high over 0..HA-1, black with active low in blanking.
    task automatic checkPlainRow(input string tag);
        int bad = 0;
        for (int i = 0; i < HT; i++) begin
            if (i < HA) begin
                if (rowRgb[i] !== W || rowAct[i] !== 1'b1) bad++;
            end else begin
                if (rowRgb[i] !== B || rowAct[i] !== 1'b0) bad++;
            end
        end
        checkOutput(tag, bad, 0);
    endtask

    task automatic checkBlankTail(input string tag);
        int bad = 0;
        for (int i = HA; i < HT; i++) begin
            if (rowRgb[i] !== B || rowAct[i] !== 1'b0) bad++;
        end
        checkOutput(tag, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_in    = 1'b1;
        enable_in = 1'b0;
        applyStimulus(100, 10, 4, 5);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checkOutput("reset rgb", {29'd0, rgb_out}, 0);
        checkOutput("reset active", {31'd0, active_out}, 0);
        checkOutput("reset hcount", {21'd0, hcount_out}, 0);
        checkOutput("reset vcount", {22'd0, vcount_out}, 0);
        checkOutput("reset row_start", {31'd0, row_start_out}, 0);
        checkOutput("reset frame_start", {31'd0, frame_start_out}, 0);
        checkOutput("reset centre", {21'd0, centre_out}, 0);

        // Frame 1: x=100 y=10 h=4 W=5
        monitorOn = 1'b1;
        enable_in = 1'b1;
        tick();
        checkOutput("first frame_start", {31'd0, frame_start_out}, 1);
        checkOutput("first row_start", {31'd0, row_start_out}, 1);
        checkOutput("first hcount", {21'd0, hcount_out}, 0);
        checkOutput("first vcount", {22'd0, vcount_out}, 0);
        checkOutput("first centre", {21'd0, centre_out}, 120);
        checkOutput("first rgb", {29'd0, rgb_out}, 7);
        checkOutput("first active", {31'd0, active_out}, 1);
        tick();
        checkOutput("second frame_start", {31'd0, frame_start_out}, 0);
        checkOutput("second row_start", {31'd0, row_start_out}, 0);
        checkOutput("second hcount", {21'd0, hcount_out}, 1);

        captureRow(9);
        checkPlainRow("f1 row9 plain");
        captureRow(10);
        spot("f1r10", 99, W);  spot("f1r10", 100, B); spot("f1r10", 104, B); spot("f1r10", 105, W);
        spot("f1r10", 109, W); spot("f1r10", 110, B); spot("f1r10", 114, B); spot("f1r10", 115, W);
        spot("f1r10", 124, W); spot("f1r10", 125, B); spot("f1r10", 129, B); spot("f1r10", 130, W);
        spot("f1r10", 134, W); spot("f1r10", 135, B); spot("f1r10", 139, B); spot("f1r10", 140, W);
        spot("f1r10", 639, W); spot("f1r10", 640, B);
        checkOutput("f1r10 act639", {31'd0, rowAct[639]}, 1);
        checkOutput("f1r10 act640", {31'd0, rowAct[640]}, 0);

        // Mid-frame width change must not touch the rest of this frame.
        applyStimulus(100, 10, 4, 9);

        advanceTo(11, 500);
        enable_in = 1'b0;
        repeat (50) tick();
        checkOutput("freeze hcount", {21'd0, hcount_out}, 500);
        checkOutput("freeze vcount", {22'd0, vcount_out}, 11);
        checkOutput("freeze rgb", {29'd0, rgb_out}, 7);
        checkOutput("freeze row_start", {31'd0, row_start_out}, 0);
        enable_in = 1'b1;
        tick();
        checkOutput("resume hcount", {21'd0, hcount_out}, 501);

        captureRow(13);
        spot("f1r13", 100, B); spot("f1r13", 110, B); spot("f1r13", 139, B); spot("f1r13", 140, W);
        checkOutput("f1 centre held", {21'd0, centre_out}, 120);
        captureRow(14);
        checkPlainRow("f1 row14 plain");
        captureRow(15);
        begin
            int bad = 0;
            for (int i = 0; i < HT; i++) if (rowRgb[i] !== B || rowAct[i] !== 1'b0) bad++;
            checkOutput("f1 row15 vblank", bad, 0);
        end

        // Frame 2: W=9 now in effect
        advanceTo(0, 0);
        checkOutput("f2 frame_start", {31'd0, frame_start_out}, 1);
        checkOutput("f2 centre", {21'd0, centre_out}, 136);
        captureRow(10);
        spot("f2r10", 99, W);  spot("f2r10", 100, B); spot("f2r10", 108, B); spot("f2r10", 109, W);
        spot("f2r10", 117, W); spot("f2r10", 118, B); spot("f2r10", 126, B); spot("f2r10", 127, W);
        spot("f2r10", 144, W); spot("f2r10", 145, B); spot("f2r10", 153, B); spot("f2r10", 154, W);
        spot("f2r10", 162, W); spot("f2r10", 163, B); spot("f2r10", 171, B); spot("f2r10", 172, W);
        checkOutput("frames seen", {31'd0, frameCnt >= 2}, 1);
        checkOutput("frame period", frameStamp[1] - frameStamp[0], HT * VT);
        checkOutput("rows per frame", frameRows[1] - frameRows[0], VT);

        applyStimulus(630, 10, 4, 5);

        // Frame 3: marker clipped at the right edge of the active area
        advanceTo(0, 0);
        checkOutput("f3 centre", {21'd0, centre_out}, 650);
        captureRow(10);
        spot("f3r10", 629, W); spot("f3r10", 630, B); spot("f3r10", 634, B);
        spot("f3r10", 635, W); spot("f3r10", 639, W);
        checkOutput("f3r10 act639", {31'd0, rowAct[639]}, 1);
        checkBlankTail("f3r10 blank tail");
        captureRow(11);
        spot("f3r11", 100, W); spot("f3r11", 629, W); spot("f3r11", 630, B);
        spot("f3r11", 634, B); spot("f3r11", 635, W); spot("f3r11", 639, W);
        checkBlankTail("f3r11 blank tail");
        checkOutput("row gaps", badRowGaps, 0);
        checkOutput("f2-f3 period", frameStamp[2] - frameStamp[1], HT * VT);

        applyStimulus(100, 10, 4, 0);

        // Frame 4: width 0 behaves as width 1
        advanceTo(0, 0);
        checkOutput("f4 centre", {21'd0, centre_out}, 104);
        captureRow(10);
        spot("f4r10", 99, W);  spot("f4r10", 100, B); spot("f4r10", 101, W); spot("f4r10", 102, B);
        spot("f4r10", 103, W); spot("f4r10", 104, W); spot("f4r10", 105, B); spot("f4r10", 106, W);
        spot("f4r10", 107, B); spot("f4r10", 108, W);

        // Asynchronous reset in the middle of a marker row
        applyStimulus(100, 10, 4, 5);
        advanceTo(11, 105);
        checkOutput("pre-reset rgb", {29'd0, rgb_out}, 0);
        checkOutput("pre-reset active", {31'd0, active_out}, 1);
        monitorOn = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async reset hcount", {21'd0, hcount_out}, 0);
        checkOutput("async reset vcount", {22'd0, vcount_out}, 0);
        checkOutput("async reset rgb", {29'd0, rgb_out}, 0);
        checkOutput("async reset active", {31'd0, active_out}, 0);
        checkOutput("async reset centre", {21'd0, centre_out}, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();
        checkOutput("restart frame_start", {31'd0, frame_start_out}, 1);
        checkOutput("restart hcount", {21'd0, hcount_out}, 0);
        checkOutput("restart vcount", {22'd0, vcount_out}, 0);
        checkOutput("restart centre", {21'd0, centre_out}, 120);
        captureRow(10);
        spot("r10 after reset", 110, B); spot("r10 after reset", 112, B);
        spot("r10 after reset", 114, B); spot("r10 after reset", 115, W);
        spot("r10 after reset", 120, W);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/marker_pattern_gen.md
Name: marker_pattern_gen

Overview:
- Raster test-pattern source that renders the banded marker on a 3-bit RGB pixel stream for the row-scan flip counter.
- Within a configured rectangle, each active row carries SIDE_BANDS stripes of width W, a centre band of width 2W, then SIDE_BANDS stripes, on a white quiet-zone background.
- Also emits the raster counters, row/frame strobes and the expected centre hcount, so a bench or on-chip self-test can drive the detector and check its coordinate output.

Parameters:
- H_ACTIVE, 640, active pixels per row
- H_TOTAL, 800, pixel clocks per row including blanking (must exceed H_ACTIVE)
- V_ACTIVE, 480, active rows per frame
- V_TOTAL, 525, rows per frame including blanking
- SIDE_BANDS, 3, stripes on each side of the centre band (1..7)

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  reset, asynchronous, active-high
- enable_in  in  1  advance raster when high; all state and outputs hold when low
- x_in  in  11  left edge (hcount) of the first stripe
- y_in  in  10  first marker row (vcount)
- height_in  in  10  number of marker rows
- width_in  in  8  stripe width W in pixels (0 treated as 1)
- rgb_out  out  3  pixel colour
- active_out  out  1  high during active pixels
- hcount_out  out  11  pixel index of rgb_out
- vcount_out  out  10  row index of rgb_out
- row_start_out  out  1  one-cycle pulse on hcount_out==0 of every row; drives the detector's reset
- frame_start_out  out  1  one-cycle pulse on hcount_out==0, vcount_out==0
- centre_out  out  11  expected centre hcount, x_lat+(SIDE_BANDS+1)*W_lat

Behaviour:
- Reset: hcount/vcount 0, rgb_out 3'b000, active_out 0, row_start_out 0, frame_start_out 0, centre_out 0, FSM QUIET, latched config 0.
- Raster: hcount increments on each enabled clock and wraps H_TOTAL-1 -> 0. vcount increments on that wrap and wraps V_TOTAL-1 -> 0. All outputs are registered and mutually aligned: one pixel per enabled cycle.
- Config latch: x_in, y_in, height_in and width_in are sampled when the internal raster is at (0,0), one cycle before frame_start_out. They are held for the whole frame; mid-frame input changes are ignored. centre_out updates together with frame_start_out.
- Marker row: vcount in [y_lat, y_lat+height_lat-1], 11-bit compare, with no vertical wrap past V_ACTIVE.
- Band FSM runs per row and restarts at hcount 0 in state QUIET. Band counter k: 0..2*SIDE_BANDS. Pixel counter p: 8 bits plus 1 for the 2W centre.
  - QUIET: outputs white 3'b111. On a marker row with hcount==x_lat, go to BAND with k=0, p=0.
  - BAND: colour is black 3'b000 for even k and white for odd k. The centre band is k==SIDE_BANDS; it keeps the parity colour, so with the default it is white. Band length is W, or 2W for the centre. When p reaches length-1: p=0, k+1. After the last band, go to DONE.
  - DONE: white until end of row.
- Clipping: bands reaching hcount==H_ACTIVE are cut off. The FSM is forced to DONE at hcount H_ACTIVE and is not resumed on the next row. Each row starts afresh.
- Blanking (hcount>=H_ACTIVE or vcount>=V_ACTIVE): rgb_out 3'b000, active_out 0.
- Non-marker active rows: all white.
- Total marker width: (2*SIDE_BANDS+2)*W pixels.
- x_lat>=H_ACTIVE: no marker drawn.
- enable_in low: counters, FSM and all outputs freeze, and strobes stay at their held value. Deassert enable only where strobes are low.
- Reset mid-row: immediate return to reset values. The raster restarts at (0,0) on the first enabled clock after release.

Test Plan:
- Reset then enable, x=100, y=10, h=4, W=5, defaults -> rows 10..13: hcount 100-104 black, 105-109 white, 110-114 black, 115-124 white (centre), 125-129 black, 130-134 white, 135-139 black, all other active pixels 3'b111; row 9 and row 14 all white; centre_out=120.
- W=0 -> behaves as W=1: on a marker row with x=100, pixels 100..107 read B,W,B,W,W,B,W,B; centre_out=104.
- x=630, W=5 -> bands are cut at hcount 639 (630-634 black, 635-639 white); hcount 640..799 read 000 with active_out 0; the next row restarts the pattern correctly.
- width_in changed 5->9 mid-frame -> the current frame is unchanged; the next frame uses W=9 and centre_out=x+36.
- Timing -> frame_start_out pulses exactly once every 800*525 enabled clocks; row_start_out pulses every 800 clocks; enable_in held low for 50 cycles freezes hcount_out and rgb_out.
- Assert rst_in mid-marker (hcount 112) -> outputs take reset values asynchronously; after release the pattern restarts from (0,0) on the first enabled clock. Feed to count_flips with matching thresholds -> coord_out=120.
